csr_counter_bank: RTL and testbench

//  Parametrised machine counter/timer CSR bank: mcycle, minstret, mtime/mtimecmp and NUM_HPM

---
 rtl/csr_counter_bank.sv | 271 +++++++++++++++++++++++++++
 tb/tb_csr_counter_bank.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// rtl/csr_counter_bank.sv - machine counter/timer CSR bank (mcycle, minstret, hpm, mtime/mtimecmp)
// Optional feature macro: MTIME_PRESCALE_EN (mtime ticks once per PRESCALE cycles)
module csr_counter_bank #(
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic [11:0]           rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  input  logic                  wr_en,
  input  logic [11:0]           wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_err,
  input  logic                  instret_pulse,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  mtip
);

  // Arrays keep at least one entry so a zero-HPM build still elaborates.
  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Implemented mcountinhibit bits: CY, IR and one per hpm counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [CNT_WIDTH-1:0] r_mcycle;
  logic [CNT_WIDTH-1:0] r_minstret;
  logic [CNT_WIDTH-1:0] r_hpm [HPM_N];
  logic [4:0]           r_hpmevent [HPM_N];
  logic [31:0]          r_inhibit;
  logic [CNT_WIDTH-1:0] r_mtime;
  logic [CNT_WIDTH-1:0] r_mtimecmp;
  logic                 r_mtip;
  logic [31:0]          r_rd_data;
  logic                 r_rd_valid;
  logic                 r_rd_err;
  logic                 r_wr_err;

  logic [31:0]          w_rd_val;
  logic                 w_rd_hit;
  logic                 w_wr_ok;
  logic                 w_we_inh;
  logic                 w_we_cyc_lo, w_we_cyc_hi;
  logic                 w_we_ins_lo, w_we_ins_hi;
  logic                 w_we_time_lo, w_we_time_hi;
  logic                 w_we_cmp_lo, w_we_cmp_hi;
  logic [HPM_N-1:0]     w_we_evt;
  logic [HPM_N-1:0]     w_we_hpm_lo;
  logic [HPM_N-1:0]     w_we_hpm_hi;
  logic [HPM_N-1:0]     w_hpm_hit;
  logic                 w_mtime_tick;

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign wr_err   = r_wr_err;
  assign mtip     = r_mtip;

  function automatic logic [31:0] f_lo(input logic [CNT_WIDTH-1:0] v);
    return v[31:0];
  endfunction

  // Upper half, zero-padded when CNT_WIDTH < 64.
  function automatic logic [31:0] f_hi(input logic [CNT_WIDTH-1:0] v);
    logic [63:0] t;
    t = 64'(v);
    return t[63:32];
  endfunction

  // Replace one 32-bit half of a counter, leaving the other half untouched.
  function automatic logic [CNT_WIDTH-1:0] f_set(input logic [CNT_WIDTH-1:0] v,
                                                 input logic hi, input logic [31:0] d);
    logic [63:0] t;
    t = 64'(v);
    if (hi) t[63:32] = d;
    else    t[31:0]  = d;
    return t[CNT_WIDTH-1:0];
  endfunction

  // Read address decode: current register values, so a same-cycle write is not visible.
  always_comb begin
    w_rd_hit = 1'b1;
    w_rd_val = 32'd0;
    case (rd_addr)
      12'h320:          w_rd_val = r_inhibit;
      12'hB00, 12'hC00: w_rd_val = f_lo(r_mcycle);
      12'hB80, 12'hC80: w_rd_val = f_hi(r_mcycle);
      12'hB02, 12'hC02: w_rd_val = f_lo(r_minstret);
      12'hB82, 12'hC82: w_rd_val = f_hi(r_minstret);
      12'h7C0, 12'hC01: w_rd_val = f_lo(r_mtime);
      12'h7C1, 12'hC81: w_rd_val = f_hi(r_mtime);
      12'h7C2:          w_rd_val = f_lo(r_mtimecmp);
      12'h7C3:          w_rd_val = f_hi(r_mtimecmp);
      default: begin
        w_rd_hit = 1'b0;
        for (int i = 0; i < NUM_HPM; i++) begin
          if (rd_addr == 12'(32'h323 + i)) begin
            w_rd_hit = 1'b1;
            w_rd_val = {27'd0, r_hpmevent[i]};
          end
          if (rd_addr == 12'(32'hB03 + i) || rd_addr == 12'(32'hC03 + i)) begin
            w_rd_hit = 1'b1;
            w_rd_val = f_lo(r_hpm[i]);
          end
          if (rd_addr == 12'(32'hB83 + i) || rd_addr == 12'(32'hC83 + i)) begin
            w_rd_hit = 1'b1;
            w_rd_val = f_hi(r_hpm[i]);
          end
        end
      end
    endcase
  end

  // Write address decode: one-hot enables; read-only 0xCxx shadows match nothing.
  always_comb begin
    w_wr_ok      = 1'b0;
    w_we_inh     = 1'b0;
    w_we_cyc_lo  = 1'b0;
    w_we_cyc_hi  = 1'b0;
    w_we_ins_lo  = 1'b0;
    w_we_ins_hi  = 1'b0;
    w_we_time_lo = 1'b0;
    w_we_time_hi = 1'b0;
    w_we_cmp_lo  = 1'b0;
    w_we_cmp_hi  = 1'b0;
    w_we_evt     = '0;
    w_we_hpm_lo  = '0;
    w_we_hpm_hi  = '0;
    if (wr_en) begin
      w_wr_ok = 1'b1;
      case (wr_addr)
        12'h320: w_we_inh     = 1'b1;
        12'hB00: w_we_cyc_lo  = 1'b1;
        12'hB80: w_we_cyc_hi  = 1'b1;
        12'hB02: w_we_ins_lo  = 1'b1;
        12'hB82: w_we_ins_hi  = 1'b1;
        12'h7C0: w_we_time_lo = 1'b1;
        12'h7C1: w_we_time_hi = 1'b1;
        12'h7C2: w_we_cmp_lo  = 1'b1;
        12'h7C3: w_we_cmp_hi  = 1'b1;
        default: begin
          w_wr_ok = 1'b0;
          for (int i = 0; i < NUM_HPM; i++) begin
            if (wr_addr == 12'(32'h323 + i)) begin
              w_wr_ok     = 1'b1;
              w_we_evt[i] = 1'b1;
            end
            if (wr_addr == 12'(32'hB03 + i)) begin
              w_wr_ok        = 1'b1;
              w_we_hpm_lo[i] = 1'b1;
            end
            if (wr_addr == 12'(32'hB83 + i)) begin
              w_wr_ok        = 1'b1;
              w_we_hpm_hi[i] = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Event match per hpm counter: selector k in 1..NUM_EVENTS watches event_in[k-1].
  always_comb begin
    w_hpm_hit = '0;
    for (int i = 0; i < NUM_HPM; i++) begin
      for (int k = 1; k <= NUM_EVENTS; k++) begin
        if (int'(r_hpmevent[i]) == k && event_in[k-1]) w_hpm_hit[i] = 1'b1;
      end
    end
  end

`ifdef MTIME_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] r_ps_cnt;

  assign w_mtime_tick = (r_ps_cnt == PS_W'(PRESCALE - 1));

  // Prescale divider; restarts whenever software rewrites mtime.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ps_cnt <= '0;
    end else if (w_we_time_lo || w_we_time_hi || w_mtime_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + PS_W'(1);
    end
  end
`else
  // mtime advances every cycle; PRESCALE has no effect in this build.
  assign w_mtime_tick = (PRESCALE >= 1) || 1'b1;
`endif

  // Read response register: one-cycle latency, data zeroed on miss or idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= 32'd0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_err   <= rd_en && !w_rd_hit;
      r_rd_data  <= (rd_en && w_rd_hit) ? w_rd_val : 32'd0;
    end
  end

  // Write error flag: pulses for writes that hit no writable register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && !w_wr_ok;
    end
  end

  // Control registers and counters: a write to either half beats that counter's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inhibit  <= 32'd0;
      r_mcycle   <= '0;
      r_minstret <= '0;
      for (int i = 0; i < HPM_N; i++) begin
        r_hpm[i]      <= '0;
        r_hpmevent[i] <= 5'd0;
      end
    end else begin
      if (w_we_inh) r_inhibit <= wr_data & INH_MASK;

      if (w_we_cyc_lo || w_we_cyc_hi) r_mcycle <= f_set(r_mcycle, w_we_cyc_hi, wr_data);
      else if (!r_inhibit[0])         r_mcycle <= r_mcycle + CNT_ONE;

      if (w_we_ins_lo || w_we_ins_hi)        r_minstret <= f_set(r_minstret, w_we_ins_hi, wr_data);
      else if (instret_pulse && !r_inhibit[2]) r_minstret <= r_minstret + CNT_ONE;

      for (int i = 0; i < NUM_HPM; i++) begin
        if (w_we_evt[i]) r_hpmevent[i] <= wr_data[4:0];
        if (w_we_hpm_lo[i] || w_we_hpm_hi[i])
          r_hpm[i] <= f_set(r_hpm[i], w_we_hpm_hi[i], wr_data);
        else if (w_hpm_hit[i] && !r_inhibit[3+i])
          r_hpm[i] <= r_hpm[i] + CNT_ONE;
      end
    end
  end

  // Timer and compare registers; mtime ignores mcountinhibit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      if (w_we_time_lo || w_we_time_hi) r_mtime <= f_set(r_mtime, w_we_time_hi, wr_data);
      else if (w_mtime_tick)            r_mtime <= r_mtime + CNT_ONE;

      if (w_we_cmp_lo || w_we_cmp_hi) r_mtimecmp <= f_set(r_mtimecmp, w_we_cmp_hi, wr_data);
    end
  end

  // Timer interrupt: registered full-width unsigned compare of current mtime/mtimecmp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// tb/tb_csr_counter_bank.sv - randomized self-checking bench for csr_counter_bank
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic        instret_pulse;
  logic [7:0]  event_in;
  logic        mtip;

  always #5 clk = ~clk;

  csr_counter_bank dut (
    .clk(clk), .resetn(resetn),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .instret_pulse(instret_pulse), .event_in(event_in), .mtip(mtip)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: m_ctr[0]=mcycle, [1]=mtime, [2]=minstret, [3..6]=hpm3..6.
  localparam logic [31:0] INH_IMPL = 32'h0000_007D;
  logic [63:0] m_ctr [7];
  logic [63:0] m_cmp;
  logic [31:0] m_inh;
  int          m_evt [4];

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) m_ctr[i] = 64'd0;
    for (int i = 0; i < 4; i++) m_evt[i] = 0;
    m_cmp = {64{1'b1}};
    m_inh = 32'd0;
  endfunction

  function automatic bit model_read(input logic [11:0] a, output logic [31:0] d);
    int idx;
    d = 32'd0;
    if (a == 12'h320) begin d = m_inh; return 1'b1; end
    if (a >= 12'h323 && a <= 12'h326) begin d = 32'(m_evt[int'(a) - 'h323]); return 1'b1; end
    if (a >= 12'h7C0 && a <= 12'h7C3) begin
      case (a[1:0])
        2'd0: d = m_ctr[1][31:0];
        2'd1: d = m_ctr[1][63:32];
        2'd2: d = m_cmp[31:0];
        default: d = m_cmp[63:32];
      endcase
      return 1'b1;
    end
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
      idx = int'(a[4:0]);
      if (idx <= 6 && !(idx == 1 && a[11:8] == 4'hB)) begin
        d = a[7] ? m_ctr[idx][63:32] : m_ctr[idx][31:0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit model_writable(input logic [11:0] a);
    logic [31:0] dummy;
    return model_read(a, dummy) && (a[11:8] != 4'hC);
  endfunction

  // Advance the model by one edge using the current inputs, then check the DUT after the edge.
  task automatic step();
    logic [31:0] exp_rd;
    bit          rd_ok;
    bit          do_rd;
    bit          exp_werr;
    bit          exp_mtip;
    logic [63:0] nx [7];
    logic [63:0] n_cmp;
    logic [31:0] n_inh;
    int          n_evt [4];
    int          idx;
    logic [11:0] ra;

    do_rd = rd_en;
    ra    = rd_addr;
    rd_ok = 1'b0;
    exp_rd = 32'd0;
    if (rd_en) rd_ok = model_read(rd_addr, exp_rd);
    exp_mtip = (m_ctr[1] >= m_cmp);

    for (int i = 0; i < 7; i++) nx[i] = m_ctr[i];
    n_cmp = m_cmp;
    n_inh = m_inh;
    for (int i = 0; i < 4; i++) n_evt[i] = m_evt[i];

    if (!m_inh[0]) nx[0] = m_ctr[0] + 64'd1;
    nx[1] = m_ctr[1] + 64'd1;
    if (instret_pulse && !m_inh[2]) nx[2] = m_ctr[2] + 64'd1;
    for (int i = 0; i < 4; i++)
      if (!m_inh[3+i] && m_evt[i] >= 1 && m_evt[i] <= 8 && event_in[m_evt[i]-1])
        nx[3+i] = m_ctr[3+i] + 64'd1;

    exp_werr = 1'b0;
    if (wr_en) begin
      if (!model_writable(wr_addr)) begin
        exp_werr = 1'b1;
      end else if (wr_addr == 12'h320) begin
        n_inh = wr_data & INH_IMPL;
      end else if (wr_addr >= 12'h323 && wr_addr <= 12'h326) begin
        n_evt[int'(wr_addr) - 'h323] = int'(wr_data[4:0]);
      end else if (wr_addr >= 12'h7C0 && wr_addr <= 12'h7C3) begin
        case (wr_addr[1:0])
          2'd0: nx[1] = {m_ctr[1][63:32], wr_data};
          2'd1: nx[1] = {wr_data, m_ctr[1][31:0]};
          2'd2: n_cmp = {m_cmp[63:32], wr_data};
          default: n_cmp = {wr_data, m_cmp[31:0]};
        endcase
      end else begin
        idx = int'(wr_addr[4:0]);
        nx[idx] = wr_addr[7] ? {wr_data, m_ctr[idx][31:0]} : {m_ctr[idx][63:32], wr_data};
      end
    end

    for (int i = 0; i < 7; i++) m_ctr[i] = nx[i];
    for (int i = 0; i < 4; i++) m_evt[i] = n_evt[i];
    m_cmp = n_cmp;
    m_inh = n_inh;

    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, do_rd);
    if (do_rd) begin
      check($sformatf("rd_err@%03h", ra), rd_err, !rd_ok);
      check($sformatf("rd_data@%03h", ra), rd_data, rd_ok ? exp_rd : 32'd0);
    end
    check("wr_err", wr_err, exp_werr);
    check("mtip", mtip, exp_mtip);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    step();
    d = rd_data;
    rd_en = 1'b0;
  endtask

  logic [11:0] addr_tab [$] = '{12'h320, 12'h321, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327,
                                12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB06, 12'hB07, 12'hB80,
                                12'hB82, 12'hB83, 12'hB86, 12'hC00, 12'hC01, 12'hC02, 12'hC03,
                                12'hC06, 12'hC80, 12'hC81, 12'hC82, 12'hC86, 12'h7C0, 12'h7C1,
                                12'h7C2, 12'h7C3, 12'h400, 12'h000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] frozen;
    bit          seen;
    logic [11:0] a;

    resetn = 1'b0; rd_en = 1'b0; rd_addr = 12'h0; wr_en = 1'b0; wr_addr = 12'h0;
    wr_data = 32'h0; instret_pulse = 1'b0; event_in = 8'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset rd_err", rd_err, 1'b0);
    check("reset wr_err", wr_err, 1'b0);
    check("reset mtip", mtip, 1'b0);
    resetn = 1'b1;

    // Free-running mcycle after reset.
    repeat (10) step();
    do_read(12'hB00, d);
    check("mcycle after 10", d, 32'd10);
    step();
    do_read(12'h7C3, d);
    check("mtimecmp hi reset", d, 32'hFFFF_FFFF);

    // Low-to-high carry.
    do_write(12'hB00, 32'hFFFF_FFFF);
    do_write(12'hB80, 32'h0);
    step();
    do_read(12'hB80, d);
    check("mcycle carry hi", d, 32'd1);
    do_read(12'hB00, d);
    check("mcycle carry lo small", d <= 32'd1, 1'b1);

    // Inhibit freezes mcycle/minstret; writes still land.
    instret_pulse = 1'b1;
    do_write(12'h320, 32'h5);
    do_write(12'hB00, 32'h100);
    do_write(12'hB02, 32'h200);
    repeat (4) step();
    do_read(12'hB00, d);
    check("mcycle inhibited", d, 32'h100);
    do_read(12'hB02, d);
    check("minstret inhibited", d, 32'h200);
    do_read(12'h320, d);
    check("mcountinhibit rd", d, 32'h5);
    do_write(12'h320, 32'h0);
    repeat (3) step();
    do_read(12'hB02, d);
    check("minstret resumed", d, 32'h203);
    instret_pulse = 1'b0;

    // hpm3 event selection.
    do_write(12'h323, 32'h2);
    event_in = 8'h02; repeat (3) step();
    event_in = 8'h01; repeat (5) step();
    event_in = 8'h00;
    do_read(12'hB03, d);
    check("hpm3 count", d, 32'd3);
    do_write(12'h323, 32'h0);
    event_in = 8'h02; repeat (3) step();
    event_in = 8'h00;
    do_read(12'hB03, d);
    check("hpm3 held", d, 32'd3);

    // Timer compare.
    do_write(12'h7C0, 32'h0);
    do_write(12'h7C2, 32'd20);
    do_write(12'h7C3, 32'h0);
    check("mtip low before", mtip, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mtip) seen = 1'b1;
    end
    check("mtip rose", seen, 1'b1);
    do_read(12'h7C0, d);
    check("mtime at mtip+1", d, 32'd21);
    do_write(12'h7C3, 32'h1);
    step();
    check("mtip cleared", mtip, 1'b0);

    // Error paths and read-before-write.
    do_write(12'hC00, 32'h1234);
    check("wr_err ro", wr_err, 1'b1);
    do_read(12'h400, d);
    check("rd_err unmapped", rd_err, 1'b1);
    check("rd_data unmapped", d, 32'd0);
    do_write(12'hB02, 32'h55);
    rd_en = 1'b1; rd_addr = 12'hB02; wr_en = 1'b1; wr_addr = 12'hB02; wr_data = 32'hABC;
    step();
    check("rd before wr", rd_data, 32'h55);
    rd_en = 1'b0; wr_en = 1'b0;
    do_read(12'hB02, d);
    check("wr landed", d, 32'hABC);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_addr = addr_tab[$urandom_range(0, addr_tab.size() - 1)];
      wr_en   = ($urandom_range(0, 3) == 0);
      a       = addr_tab[$urandom_range(0, addr_tab.size() - 1)];
      wr_addr = a;
      case (a)
        12'h7C2: wr_data = m_ctr[1][31:0] + $urandom_range(0, 40);
        12'h7C3: wr_data = m_ctr[1][63:32] + $urandom_range(0, 1);
        12'h7C1: wr_data = 32'd0;
        12'h323, 12'h324, 12'h325, 12'h326: wr_data = $urandom_range(0, 12);
        12'h320: wr_data = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
        default: wr_data = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                       : $urandom;
      endcase
      instret_pulse = ($urandom_range(0, 1) == 1);
      event_in      = 8'($urandom);
      step();
    end
    rd_en = 1'b0; wr_en = 1'b0; instret_pulse = 1'b0; event_in = 8'h0;

    // Asynchronous reset with a read in flight.
    rd_en = 1'b1; rd_addr = 12'hB00;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async rst mtip", mtip, 1'b0);
    @(posedge clk);
    #1;
    check("dropped rd_valid", rd_valid, 1'b0);
    check("dropped rd_data", rd_data, 32'd0);
    rd_en = 1'b0;
    model_reset();
    resetn = 1'b1;
    repeat (5) step();
    do_read(12'hB00, d);
    check("mcycle after rst", d, 32'd5);
    do_read(12'h7C2, d);
    check("mtimecmp lo after rst", d, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
